// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Raster timing generator with window blanking and a fetch port LEAD ahead.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
  parameter int   CW       = 10,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_ACT   = 1'b0,
  parameter logic VS_ACT   = 1'b0,
  parameter int   WIN_X0   = 0,
  parameter int   WIN_W    = 512,
  parameter int   WIN_Y0   = 0,
  parameter int   WIN_H    = 480,
  parameter int   SCALE_SH = 1,
  parameter int   LEAD     = 2
) (
  input  logic          vga_clk,
  input  logic          Reset,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic          fetch_en,
  output logic [CW-1:0] fetch_wx,
  output logic [CW-1:0] fetch_wy,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic          h_blank,
  output logic          v_blank,
  output logic          line_start,
  output logic          frame_start,
  output logic          odd_frame
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // LEAD=0 still needs the output register, so total latency is at least one.
  localparam int c_DEPTH   = (LEAD == 0) ? 1 : LEAD;
  localparam int c_STAGES  = c_DEPTH - 1;

  localparam logic [CW-1:0] c_H_LAST = CW'(c_H_TOTAL - 1);
  localparam logic [CW-1:0] c_V_LAST = CW'(c_V_TOTAL - 1);
  localparam logic [CW-1:0] c_WX0_N  = CW'(WIN_X0);
  localparam logic [CW-1:0] c_WY0_N  = CW'(WIN_Y0);

  localparam logic [CW:0] c_HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] c_HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] c_VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] c_VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0] c_H_ACT  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] c_V_ACT  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] c_WX0    = (CW+1)'(WIN_X0);
  localparam logic [CW:0] c_WX1    = (CW+1)'(WIN_X0 + WIN_W);
  localparam logic [CW:0] c_WY0    = (CW+1)'(WIN_Y0);
  localparam logic [CW:0] c_WY1    = (CW+1)'(WIN_Y0 + WIN_H);

  function automatic logic f_in(input logic [CW-1:0] v,
                                input logic [CW:0]   lo,
                                input logic [CW:0]   hi);
    return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
  endfunction

  logic [CW-1:0] r_hc;
  logic [CW-1:0] r_vc;
  logic [CW-1:0] w_dx;
  logic [CW-1:0] w_dy;
  logic          w_fetch_en;
  logic [CW-1:0] w_lx;
  logic [CW-1:0] w_ly;
  logic          w_lv;
  logic          w_first;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (r_hc == c_H_LAST) begin
      r_hc <= '0;
      r_vc <= (r_vc == c_V_LAST) ? '0 : r_vc + CW'(1);
    end else begin
      r_hc <= r_hc + CW'(1);
    end
  end

  assign w_fetch_en = f_in(r_hc, c_WX0, c_WX1) && f_in(r_vc, c_WY0, c_WY1);
  assign w_dx       = r_hc - c_WX0_N;
  assign w_dy       = r_vc - c_WY0_N;

  assign fetch_x  = r_hc;
  assign fetch_y  = r_vc;
  assign fetch_en = w_fetch_en;
  assign fetch_wx = w_fetch_en ? (w_dx >> SCALE_SH) : '0;
  assign fetch_wy = w_fetch_en ? (w_dy >> SCALE_SH) : '0;

  generate
    if (c_STAGES == 0) begin : g_direct
      assign w_lx = r_hc;
      assign w_ly = r_vc;
      assign w_lv = 1'b1;
    end else begin : g_pipe
      logic [CW-1:0]       r_px [c_STAGES];
      logic [CW-1:0]       r_py [c_STAGES];
      logic [c_STAGES-1:0] r_pv;

      // Position data needs no reset; the valid bits gate its use.
      always_ff @(posedge vga_clk) begin
        if (Reset) begin
          r_pv <= '0;
        end else begin
          r_pv[0] <= 1'b1;
          r_px[0] <= r_hc;
          r_py[0] <= r_vc;
          for (int i = 1; i < c_STAGES; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_px[i] <= r_px[i-1];
            r_py[i] <= r_py[i-1];
          end
        end
      end

      assign w_lx = r_px[c_STAGES-1];
      assign w_ly = r_py[c_STAGES-1];
      assign w_lv = r_pv[c_STAGES-1];
    end
  endgenerate

  assign w_first = (w_lx == '0) && (w_ly == '0);

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      DrawX       <= '0;
      DrawY       <= '0;
      hs          <= ~HS_ACT;
      vs          <= ~VS_ACT;
      de          <= 1'b0;
      h_blank     <= 1'b1;
      v_blank     <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      odd_frame   <= 1'b0;
    end else if (w_lv) begin
      DrawX       <= w_lx;
      DrawY       <= w_ly;
      hs          <= f_in(w_lx, c_HS_BEG, c_HS_END) ? HS_ACT : ~HS_ACT;
      vs          <= f_in(w_ly, c_VS_BEG, c_VS_END) ? VS_ACT : ~VS_ACT;
      de          <= f_in(w_lx, '0, c_H_ACT) && f_in(w_ly, '0, c_V_ACT);
      h_blank     <= ~f_in(w_lx, c_WX0, c_WX1);
      v_blank     <= ~f_in(w_ly, c_WY0, c_WY1);
      line_start  <= (w_lx == '0);
      frame_start <= w_first;
      odd_frame   <= odd_frame ^ w_first;
    end
  end

endmodule
`default_nettype wire
